// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue slice: operand widths, ALU operation codes,
// MIPS opcode/funct constants and the decoded-operation record.
package alu_issue_pkg;

    typedef logic [3:0]  i4;
    typedef logic [31:0] i32;

    typedef enum logic [3:0] {
        ALU_ADD     = 4'h0,
        ALU_SUB     = 4'h1,
        ALU_AND     = 4'h2,
        ALU_OR      = 4'h3,
        ALU_NOR     = 4'h4,
        ALU_XOR     = 4'h5,
        ALU_SRA     = 4'h6,
        ALU_SRL     = 4'h7,
        ALU_SLTU    = 4'h8,
        ALU_SLT     = 4'h9,
        ALU_ILLEGAL = 4'hE,
        ALU_PASS    = 4'hF
    } alu_funct_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        alu_funct_t  funct;
        i32          in1;
        i32          in2;
        logic [4:0]  wdst;
        logic        wen;
        logic        illegal;
    } issue_t;

    function automatic i32 sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic i32 zext16(input logic [15:0] imm);
        return {16'b0, imm};
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS decode: maps one instruction plus its register reads
// onto an ALU operation code, two operands and a destination.
module alu_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output issue_t      dec
);

    logic [5:0]  opcode;
    logic [4:0]  rs_field;
    logic [4:0]  rt_field;
    logic [4:0]  rd_field;
    logic [4:0]  shamt;
    logic [5:0]  fn;
    logic [15:0] imm16;

    assign opcode   = instr[31:26];
    assign rs_field = instr[25:21];
    assign rt_field = instr[20:16];
    assign rd_field = instr[15:11];
    assign shamt    = instr[10:6];
    assign fn       = instr[5:0];
    assign imm16    = instr[15:0];

    alu_funct_t  d_funct;
    logic [31:0] d_in1;
    logic [31:0] d_in2;
    logic [4:0]  d_wdst;
    logic        d_legal;

    always_comb begin
        d_funct = ALU_ILLEGAL;
        d_in1   = '0;
        d_in2   = '0;
        d_wdst  = '0;
        d_legal = 1'b0;

        unique case (opcode)
            OP_RTYPE: begin
                d_wdst = rd_field;
                d_in1  = rs_val;
                d_in2  = rt_val;
                // Register-register ops need a zero shamt; immediate shifts need a zero rs field.
                unique case (fn)
                    FN_ADD, FN_ADDU: begin d_funct = ALU_ADD;  d_legal = (shamt == 5'd0); end
                    FN_SUB, FN_SUBU: begin d_funct = ALU_SUB;  d_legal = (shamt == 5'd0); end
                    FN_AND:          begin d_funct = ALU_AND;  d_legal = (shamt == 5'd0); end
                    FN_OR:           begin d_funct = ALU_OR;   d_legal = (shamt == 5'd0); end
                    FN_NOR:          begin d_funct = ALU_NOR;  d_legal = (shamt == 5'd0); end
                    FN_XOR:          begin d_funct = ALU_XOR;  d_legal = (shamt == 5'd0); end
                    FN_SLT:          begin d_funct = ALU_SLT;  d_legal = (shamt == 5'd0); end
                    FN_SLTU:         begin d_funct = ALU_SLTU; d_legal = (shamt == 5'd0); end
                    FN_SRA, FN_SRL: begin
                        d_funct = (fn == FN_SRA) ? ALU_SRA : ALU_SRL;
                        d_in1   = rt_val;
                        d_in2   = {27'b0, shamt};
                        d_legal = (rs_field == 5'd0);
                    end
                    FN_SRAV, FN_SRLV: begin
                        d_funct = (fn == FN_SRAV) ? ALU_SRA : ALU_SRL;
                        d_in1   = rt_val;
                        d_in2   = {27'b0, rs_val[4:0]};
                        d_legal = (shamt == 5'd0);
                    end
                    default: d_legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin d_funct = ALU_ADD;  d_in1 = rs_val; d_in2 = sext16(imm16); d_wdst = rt_field; d_legal = 1'b1; end
            OP_SLTI:           begin d_funct = ALU_SLT;  d_in1 = rs_val; d_in2 = sext16(imm16); d_wdst = rt_field; d_legal = 1'b1; end
            OP_SLTIU:          begin d_funct = ALU_SLTU; d_in1 = rs_val; d_in2 = sext16(imm16); d_wdst = rt_field; d_legal = 1'b1; end
            OP_ANDI:           begin d_funct = ALU_AND;  d_in1 = rs_val; d_in2 = zext16(imm16); d_wdst = rt_field; d_legal = 1'b1; end
            OP_ORI:            begin d_funct = ALU_OR;   d_in1 = rs_val; d_in2 = zext16(imm16); d_wdst = rt_field; d_legal = 1'b1; end
            OP_XORI:           begin d_funct = ALU_XOR;  d_in1 = rs_val; d_in2 = zext16(imm16); d_wdst = rt_field; d_legal = 1'b1; end
            OP_LUI:            begin d_funct = ALU_PASS; d_in2 = {imm16, 16'b0}; d_wdst = rt_field; d_legal = 1'b1; end
            default:           d_legal = 1'b0;
        endcase

        if (!d_legal) begin
            d_funct = ALU_ILLEGAL;
            d_in1   = '0;
            d_in2   = '0;
            d_wdst  = '0;
        end
    end

    always_comb begin
        dec.funct   = d_funct;
        dec.in1     = d_in1;
        dec.in2     = d_in2;
        dec.wdst    = d_wdst;
        dec.wen     = d_legal && (d_wdst != 5'd0);
        dec.illegal = !d_legal;
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes an instruction and holds it in a single
// valid/ready pipeline register in front of the execute stage.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  funct,
    output logic [31:0] in1,
    output logic [31:0] in2,
    output logic [4:0]  wdst,
    output logic        wen,
    output logic        illegal
);

    issue_t dec;
    issue_t out_data_reg;
    issue_t out_data_next;
    logic   out_valid_reg;
    logic   out_valid_next;
    logic   accept;

    alu_decode u_decode (
        .instr  (instr),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .dec    (dec)
    );

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Flush beats a same-cycle accept; accept with drain reloads without a bubble.
    always_comb begin
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        if (flush) begin
            out_valid_next = 1'b0;
        end else if (accept) begin
            out_valid_next = 1'b1;
            out_data_next  = dec;
        end else if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign funct     = i4'(out_data_reg.funct);
    assign in1       = out_data_reg.in1;
    assign in2       = out_data_reg.in2;
    assign wdst      = out_data_reg.wdst;
    assign wen       = out_data_reg.wen;
    assign illegal   = out_data_reg.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: table of decode vectors fed through a
// scoreboard, plus hand sequences for stall, flush and reset-mid-stall.
module tb_alu_issue;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [3:0]  f;
        logic [31:0] i1;
        logic [31:0] i2;
        logic [4:0]  wd;
        logic        w;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  funct;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  wdst;
    logic        wen;
    logic        illegal;

    int errors = 0;
    int checks = 0;
    int txn    = 0;

    vec_t tbl [15];
    vec_t drv_exp;
    vec_t sb [$];

    always #5 clk = ~clk;

    alu_issue dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .funct     (funct),
        .in1       (in1),
        .in2       (in2),
        .wdst      (wdst),
        .wen       (wen),
        .illegal   (illegal)
    );

    // Scoreboard monitor: sampled mid-cycle, when inputs and outputs are settled.
    always @(negedge clk) begin
        logic mv;
        vec_t e;
        mv = (sb.size() != 0);
        checks++;
        if (out_valid !== mv) begin
            errors++;
            $display("FAIL out_valid: got %b want %b at %0t", out_valid, mv, $time);
        end
        checks++;
        if (in_ready !== (!mv || out_ready)) begin
            errors++;
            $display("FAIL in_ready: got %b want %b at %0t", in_ready, (!mv || out_ready), $time);
        end
        if (mv) begin
            e = sb[0];
            checks++;
            if (funct !== e.f || in1 !== e.i1 || in2 !== e.i2 || wdst !== e.wd || wen !== e.w || illegal !== e.ill) begin
                errors++;
                $display("FAIL txn instr=%h: got f=%h in1=%h in2=%h wdst=%0d wen=%b ill=%b want f=%h in1=%h in2=%h wdst=%0d wen=%b ill=%b",
                         e.instr, funct, in1, in2, wdst, wen, illegal, e.f, e.i1, e.i2, e.wd, e.w, e.ill);
            end
            if (out_ready) begin
                txn++;
                $display("txn %0d instr=%h f=%h in1=%h in2=%h wdst=%0d wen=%b ill=%b",
                         txn, e.instr, funct, in1, in2, wdst, wen, illegal);
                void'(sb.pop_front());
            end
        end
        if (reset || flush) begin
            sb.delete();
        end else if (in_valid && (!mv || out_ready)) begin
            sb.push_back(drv_exp);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        instr    = v.instr;
        rs_val   = v.rs;
        rt_val   = v.rt;
        drv_exp  = v;
        in_valid = 1'b1;
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (out_valid !== 1'b0 || funct !== 4'h0 || in1 !== 32'h0 || in2 !== 32'h0 ||
            wdst !== 5'd0 || wen !== 1'b0 || illegal !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: got v=%b f=%h in1=%h in2=%h wdst=%0d wen=%b ill=%b rdy=%b want all zero, in_ready=1",
                     name, out_valid, funct, in1, in2, wdst, wen, illegal, in_ready);
        end
    endtask

    initial begin
        //         instr          rs_val         rt_val         f     in1            in2            wd     w     ill
        tbl[0]  = '{32'h2528FFFF, 32'h00000005, 32'h11111111, 4'h0, 32'h00000005, 32'hFFFFFFFF, 5'd8,  1'b1, 1'b0}; // addiu $t0,$t1,-1
        tbl[1]  = '{32'h00855007, 32'h00000124, 32'h80000000, 4'h6, 32'h80000000, 32'h00000004, 5'd10, 1'b1, 1'b0}; // srav
        tbl[2]  = '{32'h3C001234, 32'h00000000, 32'h22222222, 4'hF, 32'h00000000, 32'h12340000, 5'd0,  1'b0, 1'b0}; // lui $0
        tbl[3]  = '{32'h00000000, 32'h33333333, 32'h44444444, 4'hE, 32'h00000000, 32'h00000000, 5'd0,  1'b0, 1'b1}; // sll
        tbl[4]  = '{32'hFC000000, 32'h55555555, 32'h66666666, 4'hE, 32'h00000000, 32'h00000000, 5'd0,  1'b0, 1'b1}; // opcode 3F
        tbl[5]  = '{32'h00221821, 32'h00000010, 32'h00000020, 4'h0, 32'h00000010, 32'h00000020, 5'd3,  1'b1, 1'b0}; // addu
        tbl[6]  = '{32'h00A62022, 32'hDEADBEEF, 32'h01234567, 4'h1, 32'hDEADBEEF, 32'h01234567, 5'd4,  1'b1, 1'b0}; // sub
        tbl[7]  = '{32'h00223827, 32'h0F0F0F0F, 32'hF0F0F0F0, 4'h4, 32'h0F0F0F0F, 32'hF0F0F0F0, 5'd7,  1'b1, 1'b0}; // nor
        tbl[8]  = '{32'h0022482B, 32'h00000001, 32'hFFFFFFFF, 4'h8, 32'h00000001, 32'hFFFFFFFF, 5'd9,  1'b1, 1'b0}; // sltu
        tbl[9]  = '{32'h000C59C3, 32'h77777777, 32'hA5A5A5A5, 4'h6, 32'hA5A5A5A5, 32'h00000007, 5'd11, 1'b1, 1'b0}; // sra 7
        tbl[10] = '{32'h342D8001, 32'h12345678, 32'h00000000, 4'h3, 32'h12345678, 32'h00008001, 5'd13, 1'b1, 1'b0}; // ori
        tbl[11] = '{32'h282EFFFE, 32'h00000009, 32'h00000000, 4'h9, 32'h00000009, 32'hFFFFFFFE, 5'd14, 1'b1, 1'b0}; // slti -2
        tbl[12] = '{32'h00220004, 32'h00000003, 32'h00000004, 4'hE, 32'h00000000, 32'h00000000, 5'd0,  1'b0, 1'b1}; // sllv
        tbl[13] = '{32'h00220021, 32'h00000001, 32'h00000002, 4'h0, 32'h00000001, 32'h00000002, 5'd0,  1'b0, 1'b0}; // addu $0
        tbl[14] = '{32'h00221806, 32'hFFFFFFE3, 32'h0000F000, 4'h7, 32'h0000F000, 32'h00000003, 5'd3,  1'b1, 1'b0}; // srlv

        reset     = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        instr     = 32'h0;
        rs_val    = 32'h0;
        rt_val    = 32'h0;
        drv_exp   = tbl[0];
        cyc();
        cyc();
        check_reset_outputs("reset_state");
        reset = 1'b0;

        // Back-to-back table stream at full rate.
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i]);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        cyc();

        // Stall three cycles with the next op waiting, then release.
        out_ready = 1'b0;
        drive(tbl[0]);
        cyc();
        drive(tbl[1]);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_bit("stall_in_ready", in_ready, 1'b0);
            check_bit("stall_out_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        check_bit("no_bubble_valid", out_valid, 1'b1);
        checks++;
        if (funct !== 4'h6 || in2 !== 32'h4) begin
            errors++;
            $display("FAIL no_bubble_op: got f=%h in2=%h want f=6 in2=00000004", funct, in2);
        end
        cyc();
        cyc();

        // Flush plus new instruction while stalled: both dropped.
        out_ready = 1'b0;
        drive(tbl[2]);
        cyc();
        drive(tbl[3]);
        flush = 1'b1;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_bit("flush_out_valid", out_valid, 1'b0);
        cyc();

        // Reset while stalled drops the buffered op.
        drive(tbl[5]);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        reset    = 1'b0;
        in_valid = 1'b0;
        check_reset_outputs("reset_mid_stall");
        out_ready = 1'b1;
        cyc();
        cyc();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: an instruction and its operands are presented.
REQ-004 SHALL have port in_ready, output, 1 bit: the block accepts the presented instruction this cycle.
REQ-005 SHALL have port instr, input, 32 bits: MIPS instruction word.
REQ-006 SHALL have ports rs_val and rt_val, input, 32 bits each: register-file read values for rs and rt.
REQ-007 SHALL have port flush, input, 1 bit: discards the buffered instruction.
REQ-008 SHALL have port out_valid, output, 1 bit: the ALU operation is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the ALU/execute stage consumes the operation.
REQ-010 SHALL have port funct, output, 4 bits: ALU operation code.
REQ-011 SHALL have ports in1 and in2, output, 32 bits each: ALU operands.
REQ-012 SHALL have ports wdst, output, 5 bits, and wen, output, 1 bit: destination register and write enable.
REQ-013 SHALL have port illegal, output, 1 bit: the buffered instruction is not supported.

Function
REQ-014 SHALL use this ALU code map: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 nor, 0101 xor, 0110 sra, 0111 srl, 1000 sltu, 1001 slt, 1111 pass in2; all other codes produce zero.
REQ-015 SHALL decode R-type (opcode 0) funct fields as follows: ADDU/ADD->0000, SUBU/SUB->0001, AND->0010, OR->0011, NOR->0100, XOR->0101, SLT->1001, SLTU->1000; in1=rs_val, in2=rt_val, wdst=rd.
REQ-016 SHALL decode SRA/SRL with in1=rt_val and in2=zero-extended shamt; SRAV/SRLV SHALL use in1=rt_val and in2={27'b0, rs_val[4:0]}.
REQ-017 SHALL decode ADDIU/ADDI->0000, SLTI->1001 and SLTIU->1000 with a sign-extended imm16, and ANDI->0010, ORI->0011 and XORI->0101 with a zero-extended imm16; for all of these, in1=rs_val and wdst=rt.
REQ-018 SHALL decode LUI as funct=1111 with in2={imm16,16'b0}.
REQ-019 SHALL treat SLL, SLLV and any other encoding as illegal: illegal=1, funct=1110, wen=0, in1=in2=0.
REQ-020 SHALL force wen=0 when wdst==0; otherwise wen=1 for every legal instruction.
REQ-021 SHALL register all outputs in a single pipeline register: an instruction accepted in cycle N appears with out_valid=1 in cycle N+1.
REQ-022 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-023 SHALL accept an instruction when in_valid && in_ready, and SHALL complete a transfer when out_valid && out_ready.
REQ-024 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-025 SHALL, when a transfer completes with no new accept in the same cycle, clear out_valid to 0 in the next cycle.
REQ-026 SHALL, on simultaneous accept and drain, load the new instruction without a bubble, sustaining 1 op/cycle.
REQ-027 SHALL, on flush, clear out_valid to 0 next cycle and ignore any same-cycle accept; flush SHALL take priority over in_valid.

Reset
REQ-028 SHALL, on reset, set out_valid=0, funct=0000, in1=in2=0, wdst=0, wen=0 and illegal=0; reset SHALL take priority over flush and handshake.
REQ-029 SHALL drop a buffered instruction when reset is asserted mid-stall; in_ready SHALL be 1 in the first cycle after reset.

Structure
REQ-030 SHALL define the ALU code enum (alu_funct_t) and the opcode/funct constants in the shared common.svh package, reusing its i4/i32 types.
REQ-031 SHALL implement decode as one combinational sub-module, alu_decode, with the pipeline register and handshake in alu_issue.

Verification
REQ-032 SHALL cover: ADDIU $t0,$t1,-1 with rs_val=5 -> next cycle funct=0000, in1=5, in2=32'hFFFF_FFFF, wdst=8, wen=1.
REQ-033 SHALL cover: SRAV with rs_val=32'h0000_0124 and rt_val=32'h8000_0000 -> funct=0110, in1=32'h8000_0000, in2=4.
REQ-034 SHALL cover: LUI $0,0x1234 -> funct=1111, in2=32'h1234_0000, wen=0.
REQ-035 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs frozen; then out_ready=1 -> the next op appears the following cycle without a bubble.
REQ-036 SHALL cover: SLL or opcode 6'h3F -> illegal=1, funct=1110, wen=0.
REQ-037 SHALL cover: flush and in_valid asserted together while stalled -> out_valid=0 next cycle; reset mid-stall -> all outputs at reset values.
